pj_unidade_controle: RTL

- Moore FSM that sequences the MindFocus datapath (fluxo_dados) through one full game.
- Owns the zero/count/register strobes of the address counter (ContEnd), the hit counter (ContAcertos) and the button register (RegBotoes).
- Owns a per-move timeout timer, so an idle player cannot stall the game.
- Sits alongside fluxo_dados inside the top-level circuit; the top level wires fluxo_dados status signals back to this block.

---
 rtl/pj_unidade_controle.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pj_unidade_controle.sv
// pj_unidade_controle
//   Moore control unit that sequences the MindFocus datapath (fluxo_dados)
//   through one full 16-move game. It drives the clear/count/load strobes of
//   the address counter, the hit counter and the button register. It also
//   runs a per-move timeout so that an idle player cannot stall the game.
//
// Ports
//   clock              in   system clock, rising edge
//   reset              in   asynchronous reset, active low
//   iniciar            in   start/restart game (level-sampled in INICIAL/FIM)
//   jogada_feita       in   one-cycle move pulse from the datapath edge detector
//   botaoIgualMemoria  in   registered button equals the ROM word
//   fimE               in   address counter rco (address == 15)
//   zeraA/zeraE/zeraR  out  clear hit counter / address counter / button register
//   registraR          out  load button register
//   contaE / contaA    out  advance address counter / increment hit counter
//   pronto             out  game finished, score stable
//   db_timeout         out  single-cycle pulse for a timed-out move
//   db_estado          out  current state encoding
module pj_unidade_controle #(
  parameter int TIMEOUT = 5000,
  parameter int TW      = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       botaoIgualMemoria,
  input  logic       fimE,
  output logic       zeraA,
  output logic       zeraE,
  output logic       zeraR,
  output logic       registraR,
  output logic       contaE,
  output logic       contaA,
  output logic       pronto,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL  = 4'h0,
    PREPARA  = 4'h1,
    ESPERA   = 4'h2,
    REGISTRA = 4'h3,
    COMPARA  = 4'h4,
    ACERTO   = 4'h5,
    ERRO     = 4'h6,
    ESGOTADO = 4'h7,
    PROXIMA  = 4'h8,
    FIM      = 4'hF
  } estado_t;

  // Timer holds TIMEOUT-1 during the last ESPERA cycle of a move, so the
  // move leaves ESPERA exactly TIMEOUT cycles after entering it.
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  estado_t       state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          expirou;

  assign expirou = (timer_q == TMAX);

  // State and timer registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= INICIAL;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next-state and timer logic
  always_comb begin
    state_d = INICIAL;
    timer_d = timer_q;
    case (state_q)
      INICIAL:  state_d = iniciar ? PREPARA : INICIAL;
      PREPARA: begin
        state_d = ESPERA;
        timer_d = '0;
      end
      ESPERA: begin
        timer_d = timer_q + 1'b1;
        // A move arriving on the expiry cycle still counts as a move.
        if (jogada_feita)  state_d = REGISTRA;
        else if (expirou)  state_d = ESGOTADO;
        else               state_d = ESPERA;
      end
      REGISTRA: state_d = COMPARA;
      COMPARA:  state_d = botaoIgualMemoria ? ACERTO : ERRO;
      ACERTO,
      ERRO,
      ESGOTADO: state_d = fimE ? FIM : PROXIMA;
      PROXIMA: begin
        state_d = ESPERA;
        timer_d = '0;
      end
      FIM:      state_d = iniciar ? PREPARA : FIM;
      default:  state_d = INICIAL;
    endcase
  end

  // Moore output decode
  always_comb begin
    zeraA      = 1'b0;
    zeraE      = 1'b0;
    zeraR      = 1'b0;
    registraR  = 1'b0;
    contaE     = 1'b0;
    contaA     = 1'b0;
    pronto     = 1'b0;
    db_timeout = 1'b0;
    case (state_q)
      PREPARA: begin
        zeraA = 1'b1;
        zeraE = 1'b1;
        zeraR = 1'b1;
      end
      REGISTRA: registraR  = 1'b1;
      ACERTO:   contaA     = 1'b1;
      ESGOTADO: db_timeout = 1'b1;
      PROXIMA: begin
        contaE = 1'b1;
        zeraR  = 1'b1;
      end
      FIM:      pronto = 1'b1;
      default: ;
    endcase
  end

  assign db_estado = state_q;

endmodule
